// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one pipelined multiplier among NREQ requesters, with a tag pipeline routing products back.
// Optional per-requester saturating issue counters are enabled by defining MULT_ARBITER_STATS_EN.
module mult_arbiter #(
    parameter int WIDTH   = 48,
    parameter int NREQ    = 4,
    parameter int LATENCY = WIDTH + 1,
    localparam int IDW    = $clog2(NREQ),
    localparam int IFW    = $clog2(LATENCY + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic [WIDTH-1:0]        mul_a,
    output logic [WIDTH-1:0]        mul_b,
    input  logic [2*WIDTH-1:0]      mul_y,
    output logic                    rsp_valid,
    output logic [IDW-1:0]          rsp_id,
    output logic [2*WIDTH-1:0]      rsp_y,
    output logic [IFW-1:0]          inflight
`ifdef MULT_ARBITER_STATS_EN
   ,output logic [NREQ*32-1:0]      issue_cnt
`endif
);

    // Handshake: requester i issues in any cycle where req_valid[i] && req_ready[i]; there is no response backpressure.
    logic [IDW-1:0]     last_grant;
    logic [IDW-1:0]     grant_idx;
    logic [IDW-1:0]     cand;
    logic               grant_found;
    logic               issue;
    logic [LATENCY-1:0] tag_v;
    logic [IDW-1:0]     tag_id [LATENCY];

    // Search begins one past the last winner so every requester gets a turn.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(last_grant) + k) % NREQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign issue = grant_found && en && !rst;

    always_comb begin
        req_ready = '0;
        mul_a     = '0;
        mul_b     = '0;
        if (issue) begin
            req_ready[grant_idx] = 1'b1;
            mul_a = req_a[grant_idx*WIDTH +: WIDTH];
            mul_b = req_b[grant_idx*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= IDW'(NREQ - 1);
        end else if (issue) begin
            last_grant <= grant_idx;
        end
    end

    // Tag stage k holds the issue from k+1 cycles ago; the last stage lines up with mul_y.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_v <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                tag_id[i] <= '0;
            end
        end else begin
            tag_v     <= {tag_v[LATENCY-2:0], issue};
            tag_id[0] <= issue ? grant_idx : '0;
            for (int i = 1; i < LATENCY; i++) begin
                tag_id[i] <= tag_id[i-1];
            end
        end
    end

    assign rsp_valid = tag_v[LATENCY-1];
    assign rsp_id    = tag_id[LATENCY-1];
    assign rsp_y     = mul_y;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= '0;
        end else begin
            case ({issue, rsp_valid})
                2'b10:   inflight <= inflight + IFW'(1);
                2'b01:   inflight <= inflight - IFW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

`ifdef MULT_ARBITER_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_cnt <= '0;
        end else if (issue && (issue_cnt[grant_idx*32 +: 32] != 32'hFFFF_FFFF)) begin
            issue_cnt[grant_idx*32 +: 32] <= issue_cnt[grant_idx*32 +: 32] + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter: models the 49-cycle shared multiplier and scoreboards responses by id, product and cycle.
module tb_mult_arbiter;

    localparam int W   = 48;
    localparam int N   = 4;
    localparam int LAT = W + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*W-1:0]  req_a;
    logic [N*W-1:0]  req_b;
    logic [W-1:0]    mul_a;
    logic [W-1:0]    mul_b;
    logic [2*W-1:0]  mul_y;
    logic            rsp_valid;
    logic [1:0]      rsp_id;
    logic [2*W-1:0]  rsp_y;
    logic [5:0]      inflight;
`ifdef MULT_ARBITER_STATS_EN
    logic [N*32-1:0] issue_cnt;
`endif

    int vec  = 0;
    int errs = 0;
    int cyc  = 0;
    int grants [N];

    logic [1:0]     exp_id_q  [$];
    logic [2*W-1:0] exp_q     [$];
    int             exp_cyc_q [$];

    logic [W-1:0] rr_a [N] = '{48'd1000, 48'hFFFF_FFFF_FFFF, 48'd123456789, 48'h8000_0000_0000};
    logic [W-1:0] rr_b [N] = '{48'd1001, 48'hFFFF_FFFF_FFFF, 48'd987654321, 48'd3};
    logic [2*W-1:0] mpipe [LAT];

    mult_arbiter #(.WIDTH(W), .NREQ(N)) dut (
        .clk(clk), .rst(rst), .en(en),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .mul_a(mul_a), .mul_b(mul_b), .mul_y(mul_y),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_y(rsp_y),
        .inflight(inflight)
`ifdef MULT_ARBITER_STATS_EN
       ,.issue_cnt(issue_cnt)
`endif
    );

    // Clock / reset-time bookkeeping and the external multiplier model.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        mpipe[0] <= {{W{1'b0}}, mul_a} * {{W{1'b0}}, mul_b};
        for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
    end
    assign mul_y = mpipe[LAT-1];

    // Scoreboard: every response must match the oldest expected issue.
    always @(negedge clk) begin
        if (!rst && rsp_valid) begin
            vec++;
            if (exp_id_q.size() == 0) begin
                errs++;
                $display("FAIL unexpected_rsp got id=%0d y=%h at cycle %0d, want none", rsp_id, rsp_y, cyc);
            end else begin
                logic [1:0] e_id;
                logic [2*W-1:0] e_y;
                int e_c;
                e_id = exp_id_q.pop_front();
                e_y  = exp_q.pop_front();
                e_c  = exp_cyc_q.pop_front();
                if (rsp_id !== e_id || rsp_y !== e_y || cyc != e_c) begin
                    errs++;
                    $display("FAIL rsp got id=%0d y=%h cyc=%0d want id=%0d y=%h cyc=%0d",
                             rsp_id, rsp_y, cyc, e_id, e_y, e_c);
                end
            end
        end
    end

    // Driver helpers.
    task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    task automatic load_rr_ops;
        for (int i = 0; i < N; i++) set_ops(i, rr_a[i], rr_b[i]);
    endtask

    task automatic push_exp(input int id, input logic [2*W-1:0] y);
        exp_id_q.push_back(2'(id));
        exp_q.push_back(y);
        exp_cyc_q.push_back(cyc + LAT);
        grants[id]++;
    endtask

    function automatic logic [2*W-1:0] prod(input logic [W-1:0] a, input logic [W-1:0] b);
        return {{W{1'b0}}, a} * {{W{1'b0}}, b};
    endfunction

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic drain;
        int n;
        n = 0;
        while (exp_id_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        vec++;
        if (exp_id_q.size() != 0) begin
            errs++;
            $display("FAIL drain_timeout got %0d pending want 0", exp_id_q.size());
            exp_id_q.delete(); exp_q.delete(); exp_cyc_q.delete();
        end
        vec++;
        if (inflight !== 6'd0) begin
            errs++;
            $display("FAIL drain_inflight got %0d want 0", inflight);
        end
        next_cycle();
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b1; req_valid = 4'hF;
        load_rr_ops();
        @(negedge clk);
        vec++; if (req_ready !== 4'b0000) begin errs++; $display("FAIL reset_ready got %b want 0000", req_ready); end
        vec++; if (mul_a !== '0 || mul_b !== '0) begin errs++; $display("FAIL reset_mul got a=%h b=%h want 0", mul_a, mul_b); end
        vec++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        vec++; if (rsp_id !== 2'd0) begin errs++; $display("FAIL reset_rsp_id got %0d want 0", rsp_id); end
        vec++; if (inflight !== 6'd0) begin errs++; $display("FAIL reset_inflight got %0d want 0", inflight); end
        next_cycle();
        rst = 1'b0; req_valid = 4'h0;
    endtask

    task automatic test_round_robin;
        logic [3:0] want;
        int g;
        req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            g = k % N;
            want = 4'b0001 << g;
            @(negedge clk);
            vec++; if (req_ready !== want) begin errs++; $display("FAIL rr_grant[%0d] got %b want %b", k, req_ready, want); end
            vec++; if (mul_a !== rr_a[g] || mul_b !== rr_b[g]) begin errs++; $display("FAIL rr_ops[%0d] got a=%h b=%h want a=%h b=%h", k, mul_a, mul_b, rr_a[g], rr_b[g]); end
            push_exp(g, prod(rr_a[g], rr_b[g]));
            next_cycle();
        end
        req_valid = 4'h0;
        drain();
    endtask

    task automatic test_single;
        req_valid = 4'b0001;
        set_ops(0, 48'd3, 48'd5);
        @(negedge clk);
        vec++; if (req_ready !== 4'b0001) begin errs++; $display("FAIL single_grant got %b want 0001", req_ready); end
        vec++; if (mul_a !== 48'd3 || mul_b !== 48'd5) begin errs++; $display("FAIL single_ops got a=%0d b=%0d want 3 5", mul_a, mul_b); end
        push_exp(0, 96'd15);
        next_cycle();
        req_valid = 4'b0000;
        @(negedge clk);
        vec++; if (inflight !== 6'd1) begin errs++; $display("FAIL single_inflight got %0d want 1", inflight); end
        vec++; if (req_ready !== 4'b0000 || mul_a !== '0) begin errs++; $display("FAIL single_idle got ready=%b a=%h want 0000 0", req_ready, mul_a); end
        next_cycle();
        drain();
    endtask

    task automatic test_back_to_back;
        req_valid = 4'b0100;
        set_ops(2, 48'h8000_0000_0000, 48'd2);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            vec++; if (req_ready !== 4'b0100) begin errs++; $display("FAIL b2b_grant[%0d] got %b want 0100", k, req_ready); end
            vec++; if (inflight !== 6'(k)) begin errs++; $display("FAIL b2b_inflight[%0d] got %0d want %0d", k, inflight, k); end
            push_exp(2, 96'h1_0000_0000_0000);
            next_cycle();
        end
    endtask

    task automatic test_enable;
        load_rr_ops();
        en = 1'b0; req_valid = 4'hF;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            vec++; if (req_ready !== 4'b0000 || mul_a !== '0) begin errs++; $display("FAIL en_off_grant[%0d] got ready=%b a=%h want 0000 0", k, req_ready, mul_a); end
            vec++; if (inflight !== 6'd4) begin errs++; $display("FAIL en_off_inflight[%0d] got %0d want 4", k, inflight); end
            next_cycle();
        end
        en = 1'b1; req_valid = 4'h0;
        @(negedge clk);
        vec++; if (req_ready !== 4'b0000 || inflight !== 6'd4) begin errs++; $display("FAIL dropped_valid got ready=%b inflight=%0d want 0000 4", req_ready, inflight); end
        next_cycle();
        req_valid = 4'hF;
        @(negedge clk);
        vec++; if (req_ready !== 4'b1000) begin errs++; $display("FAIL en_resume0 got %b want 1000", req_ready); end
        push_exp(3, prod(rr_a[3], rr_b[3]));
        next_cycle();
        @(negedge clk);
        vec++; if (req_ready !== 4'b0001) begin errs++; $display("FAIL en_resume1 got %b want 0001", req_ready); end
        push_exp(0, prod(rr_a[0], rr_b[0]));
        next_cycle();
        req_valid = 4'h0;
        drain();
    endtask

    task automatic test_simultaneous;
        load_rr_ops();
        req_valid = 4'b0010;
        @(negedge clk);
        vec++; if (req_ready !== 4'b0010) begin errs++; $display("FAIL sim_grant0 got %b want 0010", req_ready); end
        push_exp(1, prod(rr_a[1], rr_b[1]));
        next_cycle();
        req_valid = 4'b0000;
        repeat (LAT - 1) @(posedge clk);
        #1;
        req_valid = 4'b0010;
        @(negedge clk);
        vec++; if (rsp_valid !== 1'b1 || req_ready !== 4'b0010) begin errs++; $display("FAIL sim_overlap got rsp_valid=%b ready=%b want 1 0010", rsp_valid, req_ready); end
        vec++; if (inflight !== 6'd1) begin errs++; $display("FAIL sim_inflight_before got %0d want 1", inflight); end
        push_exp(1, prod(rr_a[1], rr_b[1]));
        next_cycle();
        req_valid = 4'b0000;
        @(negedge clk);
        vec++; if (inflight !== 6'd1) begin errs++; $display("FAIL sim_inflight_after got %0d want 1", inflight); end
        next_cycle();
        drain();
    endtask

    task automatic test_reset_mid;
        logic [3:0] want;
        int order [5] = '{2, 3, 0, 1, 2};
        load_rr_ops();
        req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            want = 4'b0001 << order[k];
            @(negedge clk);
            vec++; if (req_ready !== want) begin errs++; $display("FAIL mid_grant[%0d] got %b want %b", k, req_ready, want); end
            next_cycle();
        end
        req_valid = 4'h0;
        repeat (20) next_cycle();
        @(negedge clk);
        vec++; if (inflight !== 6'd5) begin errs++; $display("FAIL mid_inflight got %0d want 5", inflight); end
        next_cycle();
        rst = 1'b1; req_valid = 4'hF;
        @(negedge clk);
        vec++; if (req_ready !== 4'b0000 || inflight !== 6'd0 || rsp_valid !== 1'b0) begin errs++; $display("FAIL mid_reset got ready=%b inflight=%0d rsp_valid=%b want 0000 0 0", req_ready, inflight, rsp_valid); end
        for (int i = 0; i < N; i++) grants[i] = 0;
        next_cycle();
        rst = 1'b0; req_valid = 4'h0;
        repeat (60) next_cycle();
        @(negedge clk);
        vec++; if (inflight !== 6'd0) begin errs++; $display("FAIL post_reset_inflight got %0d want 0", inflight); end
        next_cycle();
        req_valid = 4'hF;
        @(negedge clk);
        vec++; if (req_ready !== 4'b0001) begin errs++; $display("FAIL post_reset_grant got %b want 0001", req_ready); end
        push_exp(0, prod(rr_a[0], rr_b[0]));
        next_cycle();
        req_valid = 4'h0;
        drain();
    endtask

`ifdef MULT_ARBITER_STATS_EN
    task automatic test_stats;
        for (int i = 0; i < N; i++) begin
            vec++;
            if (issue_cnt[i*32 +: 32] !== 32'(grants[i])) begin
                errs++;
                $display("FAIL stats[%0d] got %0d want %0d", i, issue_cnt[i*32 +: 32], grants[i]);
            end
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < N; i++) grants[i] = 0;
        req_a = '0; req_b = '0;
        test_reset();
        test_round_robin();
        test_single();
        test_back_to_back();
        test_enable();
        test_simultaneous();
`ifdef MULT_ARBITER_STATS_EN
        test_stats();
`endif
        test_reset_mid();
`ifdef MULT_ARBITER_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

    initial begin
        #200000;
        errs++;
        $display("FAIL watchdog got timeout want completion");
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 48, which sets the operand width and matches the shared multiplier.
REQ-002 The block SHALL have parameter NREQ, default 4, which sets the number of requesters; legal range is 2..8.
REQ-003 The block SHALL have parameter LATENCY, default WIDTH+1, which sets the number of cycles from issue to product at mul_y.
REQ-004 The block SHALL have the following ports (name, direction, width, meaning), clock and reset first:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset; asynchronous, active-high.
- en  in  1  grant enable; new grants only while high.
- req_valid  in  NREQ  per-requester operand valid.
- req_ready  out  NREQ  per-requester grant, one-hot or zero.
- req_a  in  NREQ*WIDTH  operand A; requester i at slice [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  operand B, same packing as req_a.
- mul_a  out  WIDTH  operand A to the shared multiplier.
- mul_b  out  WIDTH  operand B to the shared multiplier.
- mul_y  in  2*WIDTH  product from the shared multiplier.
- rsp_valid  out  1  result valid.
- rsp_id  out  clog2(NREQ)  index of the requester owning the result.
- rsp_y  out  2*WIDTH  result, equal to mul_y.
- inflight  out  clog2(LATENCY+1)  count of issued, not yet returned operations.

Function
REQ-005 The arbiter SHALL assert req_ready for at most one requester per cycle, and only when en=1 and that requester's req_valid=1.
REQ-006 The arbiter SHALL select by round-robin: the search starts at last_grant+1, wraps modulo NREQ, and takes the first valid requester.
REQ-007 The arbiter SHALL update last_grant only on an issue; with no issue, priority SHALL be unchanged.
REQ-008 An issue SHALL occur in a cycle when req_valid[i] and req_ready[i] are both 1.
REQ-009 During an issue cycle, mul_a and mul_b SHALL combinationally carry requester i's operands.
REQ-010 In a cycle with no issue, mul_a and mul_b SHALL be 0.
REQ-011 The block SHALL hold a tag pipeline of LATENCY stages, each stage holding {valid, id}; on each clock edge an issue enters with {1, i} and a non-issue enters with {0, x}.
REQ-012 For an issue in cycle n, rsp_valid SHALL be 1 in cycle n+LATENCY, with rsp_id=i and rsp_y=mul_y.
REQ-013 There SHALL be no backpressure on the response side: every issued operation SHALL return exactly once and in issue order.
REQ-014 Throughput SHALL be one issue per cycle, with back-to-back issues from the same or different requesters allowed.
REQ-015 inflight SHALL increment on an issue and decrement on rsp_valid; simultaneous issue and return SHALL leave it unchanged.
REQ-016 When en falls, no new grants SHALL be made, and in-flight operations SHALL still complete and return.
REQ-017 A requester that drops req_valid before being granted SHALL NOT be issued.

Reset
REQ-018 While rst=1, the block SHALL drive req_ready=0, mul_a=0, mul_b=0, rsp_valid=0, rsp_id=0, inflight=0, clear all tag valids, and set last_grant=NREQ-1 so requester 0 has first priority.
REQ-019 Reset asserted mid-operation SHALL discard all in-flight tags: no rsp_valid SHALL appear for operations issued before reset.
REQ-020 Normal operation SHALL resume on the first rising edge after rst deasserts.

Configuration
REQ-021 Macro MULT_ARBITER_STATS_EN SHALL control issue statistics.
- When defined: the block SHALL have outputs issue_cnt[NREQ*32], one saturating 32-bit issue counter per requester; reset clears them to 0.
- When not defined: these ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-022 The bench SHALL cover the following directed scenarios (WIDTH=48, NREQ=4):
- Single request: req_valid=0001, a=3, b=5, issued in cycle 10 -> rsp_valid in cycle 59, rsp_id=0, rsp_y=15.
- All valid, held for 8 cycles -> grant order 0,1,2,3,0,1,2,3; responses in the same order, 49 cycles later each.
- Back-to-back issues from requester 2 only (a=2^47, b=2) for 4 cycles -> 4 consecutive responses, each 2^48, rsp_id=2.
- en=0 with all requesters valid -> req_ready=0000 and inflight constant; en=1 -> granting resumes at last_grant+1.
- rst asserted 20 cycles after 5 issues -> no responses appear afterwards, inflight=0, and the first grant after reset goes to requester 0.
- Simultaneous issue and return -> inflight unchanged; with MULT_ARBITER_STATS_EN, issue_cnt matches the number of grants per requester.
